// File: rtl/axi_chan_arb_mux_2x1.sv
// axi_chan_arb_mux_2x1
// Merges two valid/ready/last source channels onto one downstream channel.
// Round-robin arbitration with the grant locked from arbitration until the
// beat carrying last is accepted. There is one IDLE cycle between bursts.
//
// Build option:
//   ARB_MUX_BEAT_CNT_EN - adds the beat_cnt port and a saturating counter of
//                         beats accepted in the current burst.
//
// Ports:
//   ACLK, ARESETN            clock, asynchronous active-low reset
//   in1_*/in2_*              source channels (data/valid/last in, ready out)
//   out_data/valid/last      merged channel (zero-masked while idle)
//   out_ready                downstream ready
//   grant                    one-hot owner (bit0 = in1, bit1 = in2), 00 idle
//   busy                     high while a burst is granted
//   beat_cnt                 beats accepted in the current burst (option only)
module axi_chan_arb_mux_2x1 #(
  parameter int unsigned width = 31,
  parameter int unsigned CNT_W = 8
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic [width:0]   in1_data,
  input  logic             in1_valid,
  input  logic             in1_last,
  output logic             in1_ready,
  input  logic [width:0]   in2_data,
  input  logic             in2_valid,
  input  logic             in2_last,
  output logic             in2_ready,
  output logic [width:0]   out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic [1:0]       grant,
  output logic             busy
`ifdef ARB_MUX_BEAT_CNT_EN
  ,
  output logic [CNT_W-1:0] beat_cnt
`endif
);

  localparam int unsigned DataW = width + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT1 = 2'd1,
    GNT2 = 2'd2
  } state_t;

  typedef enum logic {
    SRC1 = 1'b0,
    SRC2 = 1'b1
  } src_t;

  state_t state, state_d;
  src_t   last_srv, last_srv_d;

  // State and round-robin pointer; reset favours in1 on the first tie.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state    <= IDLE;
      last_srv <= SRC2;
    end else begin
      state    <= state_d;
      last_srv <= last_srv_d;
    end
  end

  // Arbitration, burst lock and datapath steering.
  always_comb begin
    state_d    = state;
    last_srv_d = last_srv;
    out_data   = DataW'(0);
    out_valid  = 1'b0;
    out_last   = 1'b0;
    in1_ready  = 1'b0;
    in2_ready  = 1'b0;
    grant      = 2'b00;
    busy       = 1'b0;

    unique case (state)
      IDLE: begin
        // last is deliberately ignored here; only valid requests a grant.
        if (in1_valid && in2_valid) begin
          state_d = (last_srv == SRC2) ? GNT1 : GNT2;
        end else if (in1_valid) begin
          state_d = GNT1;
        end else if (in2_valid) begin
          state_d = GNT2;
        end
      end

      GNT1: begin
        out_data  = in1_data;
        out_valid = in1_valid;
        out_last  = in1_last;
        in1_ready = out_ready;
        grant     = 2'b01;
        busy      = 1'b1;
        if (in1_valid && out_ready && in1_last) begin
          state_d    = IDLE;
          last_srv_d = SRC1;
        end
      end

      GNT2: begin
        out_data  = in2_data;
        out_valid = in2_valid;
        out_last  = in2_last;
        in2_ready = out_ready;
        grant     = 2'b10;
        busy      = 1'b1;
        if (in2_valid && out_ready && in2_last) begin
          state_d    = IDLE;
          last_srv_d = SRC2;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef ARB_MUX_BEAT_CNT_EN
  // Saturating count of accepted beats; cleared as the burst ends.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      beat_cnt <= CNT_W'(0);
    end else if (state != IDLE && state_d == IDLE) begin
      beat_cnt <= CNT_W'(0);
    end else if (out_valid && out_ready && (beat_cnt != {CNT_W{1'b1}})) begin
      beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end
`else
  // Keeps the counter width parameter meaningful in the counter-less build.
  if (CNT_W == 0) begin : g_cnt_w_zero
  end
`endif

endmodule

// File: doc/axi_chan_arb_mux_2x1.md
# axi_chan_arb_mux_2x1

Two-input, one-output channel merger with round-robin arbitration and burst locking: the return-path counterpart of the 1-to-2 enable-gated channel demux. Two sources, each driving a valid/ready/last channel of `width+1` data bits, compete for one downstream channel. The grant is held from arbitration until the beat carrying `last` is accepted. The block sits in the interconnect datapath wherever two masters' write-data (or two slaves' read-data) channels converge on one port.

## Interface
- `width`, default 31: data MSB index; data buses are `[width:0]`.
- `CNT_W`, default 8: beat-counter width; used only when `ARB_MUX_BEAT_CNT_EN` is defined.
- `ACLK`  in  1  clock; all state updates on rising edge.
- `ARESETN`  in  1  asynchronous, active-low reset.
- `in1_data`, `in2_data`  in  width+1  source payloads.
- `in1_valid`, `in2_valid`  in  1  source beat valid.
- `in1_last`, `in2_last`  in  1  final beat of source burst.
- `in1_ready`, `in2_ready`  out  1  source beat accepted when `inX_valid & inX_ready`.
- `out_data`  out  width+1  merged payload.
- `out_valid`  out  1  merged beat valid.
- `out_last`  out  1  merged last.
- `out_ready`  in  1  downstream ready.
- `grant`  out  2  one-hot owner; bit0 = in1, bit1 = in2; 2'b00 when idle.
- `busy`  out  1  high while a burst is granted.
- `beat_cnt`  out  CNT_W  beats accepted in current burst; present only with `ARB_MUX_BEAT_CNT_EN`.

## Operation
- The FSM has three states: IDLE, GNT1, GNT2. State, round-robin pointer `last_srv` and `beat_cnt` are registered. All other outputs are combinational from state and inputs.
- IDLE outputs: `out_valid=0`, `out_last=0`, `out_data=0`, both readies 0, `grant=00`, `busy=0`.
- Arbitration in IDLE:
  - Only in1 valid → GNT1.
  - Only in2 valid → GNT2.
  - Both valid → the source not equal to `last_srv`.
  - Neither valid → stay in IDLE.
- Arbitration samples `inX_valid` only; `last` is ignored in IDLE.
- GNTx outputs:
  - `out_data/out_valid/out_last = inX_*`.
  - `inX_ready = out_ready`; the other ready is held 0.
  - `grant` bit x = 1; `busy=1`.
  - Non-granted data is never passed; the output is zero-masked exactly like the disabled demux branch.
- Leaving GNTx: when `inX_valid & out_ready & inX_last` is true at a clock edge, go to IDLE and set `last_srv=x`.
- A grant is never revoked mid-burst, regardless of the other source's valid.
- A source dropping valid mid-burst holds the grant; `out_valid` follows it low.

## Timing
- Reset state: IDLE, `last_srv`=in2 (so in1 wins the first tie), `beat_cnt=0`. All outputs take their IDLE values immediately on `ARESETN` low, with no clock required.
- Arbitration latency: one cycle. Valid seen in IDLE at edge N is passed through from cycle N+1.
- Bubble: exactly one IDLE cycle between consecutive bursts, even when both sources are continuously valid.
- Throughput inside a burst: one beat per cycle when valid and ready are held.
- Single-beat burst (`last` on the first beat): GNTx lasts one cycle if `out_ready=1`.
- Reset asserted mid-burst: immediate return to IDLE; the partial burst is abandoned; no handshake is completed in that cycle.
- `out_ready` low: the FSM holds state; data is passed through unregistered, so stability is the source's responsibility per AXI.

## Configuration
- `ARB_MUX_BEAT_CNT_EN` defined:
  - `beat_cnt` port and counter exist.
  - The counter increments on each accepted beat in GNTx and saturates at 2^CNT_W−1.
  - It resets to 0 on the cycle the FSM returns to IDLE (so it reads 0 in IDLE), and on reset.
- Not defined: no counter logic and no `beat_cnt` port; all other behaviour is identical.

## Test plan
- Reset then idle: `ARESETN=0` mid-cycle → `grant=00`, all readies and `out_valid` 0 asynchronously; after release with no valids, the FSM stays IDLE.
- Single source: in2 sends a 4-beat burst 0xA0..0xA3 with `out_ready=1` → `grant=10` one cycle after `in2_valid`; `out_data` shows 0xA0..0xA3 on 4 consecutive cycles; `out_last` on 0xA3; next cycle `grant=00`.
- Tie and round-robin: both sources continuously valid with 2-beat bursts → grant order in1, in2, in1, in2 with one idle cycle between each; `in2_ready=0` throughout in1 bursts.
- Backpressure: in1 3-beat burst, `out_ready` toggling 1,0,0,1,1 → the grant is held; exactly 3 accepted beats; release only after the `last` beat is accepted.
- Reset mid-burst: assert `ARESETN=0` after 2 of 5 beats → immediate IDLE; after release with both valid, in1 is granted first.
- Counter (`ARB_MUX_BEAT_CNT_EN`, CNT_W=2): 6-beat burst → `beat_cnt` reads 0,1,2,3,3,3 during the burst (value before each edge), then 0 in IDLE.
